// File: rtl/jtdsp16_sio_rx_if.sv
// rtl/jtdsp16_sio_rx_if.sv - DSP16 serial output port signals (OCK, DO, SADD, OLD)
interface jtdsp16_sio_rx_if;
  logic ock;
  logic sio_do;
  logic sadd;
  logic old;

  modport master (output ock, output sio_do, output sadd, output old);
  modport slave  (input  ock, input  sio_do, input  sadd, input  old);
endinterface

// File: rtl/jtdsp16_sio_rx.sv
// rtl/jtdsp16_sio_rx.sv - DSP16 serial output receiver with left/right steering
module jtdsp16_sio_rx #(
  parameter logic [7:0] ADDR_L = 8'h00,
  parameter logic [7:0] ADDR_R = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  jtdsp16_sio_rx_if.slave     sio,
  output logic signed [15:0]  left,
  output logic signed [15:0]  right,
  output logic                sample,
  output logic        [15:0]  word,
  output logic        [7:0]   waddr,
  output logic                wvalid,
  output logic                frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, next_state;
  logic        last_ock;
  logic [3:0]  cnt;
  logic [14:0] shift;
  logic [7:0]  ashift;
  logic        got_l;
  logic        rise, start, take, done, abort;

  assign rise = sio.ock && !last_ock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (cen) state <= next_state;
  end

  // OLD is sampled as seen at the edge, so an OLD high while shifting aborts the frame
  always_comb begin
    next_state = state;
    start      = 1'b0;
    take       = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (rise && !sio.old) begin
          start      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (sio.old) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (rise) begin
          take = 1'b1;
          if (cnt == 4'd15) begin
            done       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ock  <= 1'b0;
      cnt       <= 4'd0;
      shift     <= 15'd0;
      ashift    <= 8'd0;
      word      <= 16'd0;
      waddr     <= 8'hFF;
      wvalid    <= 1'b0;
      frame_err <= 1'b0;
    end else if (cen) begin
      last_ock <= sio.ock;
      wvalid   <= 1'b0;
      if (start) begin
        shift  <= {14'd0, sio.sio_do};
        ashift <= {7'd0, sio.sadd};
        cnt    <= 4'd1;
      end else if (take) begin
        shift <= {shift[13:0], sio.sio_do};
        cnt   <= cnt + 4'd1;
        if (cnt < 4'd8) ashift <= {ashift[6:0], sio.sadd};
        if (done) begin
          word   <= {shift, sio.sio_do};
          waddr  <= ashift;
          wvalid <= 1'b1;
        end
      end else if (abort) begin
        cnt       <= 4'd0;
        frame_err <= 1'b1;
      end
    end
  end

  // Steering runs one cen cycle behind wvalid; a stereo pair is a left followed by a right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   <= 16'sd0;
      right  <= 16'sd0;
      got_l  <= 1'b0;
      sample <= 1'b0;
    end else if (cen) begin
      sample <= 1'b0;
      if (wvalid) begin
        if (waddr == ADDR_L) begin
          left  <= word;
          got_l <= 1'b1;
        end else if (waddr == ADDR_R) begin
          right <= word;
          if (got_l) begin
            sample <= 1'b1;
            got_l  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
